add32_seq: RTL and testbench

Multi-cycle 32-bit adder, the addition counterpart of the team's 32-bit subtractor datapath. Operands are accepted over a valid/ready handshake, summed 8 bits per cycle through a single shared slice adder with the carry registered between slices, and the result is held on a valid/ready output until consumed. With Cin=1 and B pre-inverted it computes A−B, so it doubles as the sequential reference for subtractor results.

---
 rtl/add32_pkg.sv | 29 ++
 rtl/add_slice.sv | 23 ++
 rtl/add32_seq.sv | 129 ++++++++++++
 tb/tb_add32_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add32_pkg.sv
// rtl/add32_pkg.sv - shared types and constants for the sequential adder
//
// Purpose: state encoding, default geometry and a width helper shared by
//          add_slice and add32_seq.
// Contents:
//   state_t    - FSM states IDLE, RUN, DONE
//   WIDTH_DEF  - default operand width (32)
//   SLICE_DEF  - default bits summed per cycle (8)
//   clog2()    - counter width for a slice count, never less than 1
package add32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 8;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational SLICE-bit adder used once per cycle
//
// Purpose: {co, s} = a + b + ci over SLICE bits.
// Ports:
//   a, b  in  SLICE  slice operands
//   ci    in  1      carry in
//   s     out SLICE  slice sum
//   co    out 1      carry out of the slice
module add_slice
  import add32_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

endmodule

// File: rtl/add32_seq.sv
// rtl/add32_seq.sv - multi-cycle adder, one SLICE-bit slice per clock
//
// Purpose: accepts A, B, Cin on a valid/ready handshake, sums them one slice
//          per cycle through a single shared add_slice with the carry
//          registered between slices, and holds Result/Cout until consumed.
// Optional feature macro: ADD32_OVERFLOW_EN adds the registered signed
//          Overflow output.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      ready for operands (IDLE only, registered)
//   A, B       in   WIDTH  operands
//   Cin        in   1      carry into bit 0
//   out_valid  out  1      Result/Cout (and Overflow) valid
//   out_ready  in   1      consumer takes the result
//   Result     out  WIDTH  A + B + Cin modulo 2^WIDTH
//   Cout       out  1      carry out of bit WIDTH-1
//   Overflow   out  1      signed overflow (ADD32_OVERFLOW_EN only)
module add32_seq
  import add32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout
`ifdef ADD32_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int            NSLICE = WIDTH / SLICE;
  localparam int            CW     = clog2(NSLICE);
  localparam logic [CW-1:0] LAST   = CW'(NSLICE - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CW-1:0]      cnt;

  logic [SLICE-1:0]   sl_a;
  logic [SLICE-1:0]   sl_b;
  logic [SLICE-1:0]   sl_s;
  logic               sl_co;

  // The one slice adder is steered to the slice selected by the counter.
  assign sl_a = a_q[cnt*SLICE +: SLICE];
  assign sl_b = b_q[cnt*SLICE +: SLICE];

  add_slice #(.SLICE(SLICE)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      Result    <= '0;
      Cout      <= 1'b0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef ADD32_OVERFLOW_EN
      Overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= A;
            b_q      <= B;
            carry_q  <= Cin;
            cnt      <= '0;
            // Uncomputed slices read 0 while the operation runs.
            Result   <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          Result[cnt*SLICE +: SLICE] <= sl_s;
          carry_q <= sl_co;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            Cout      <= sl_co;
`ifdef ADD32_OVERFLOW_EN
            // Top bit of the final slice sum is Result[WIDTH-1].
            Overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (sl_s[SLICE-1] != a_q[WIDTH-1]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Ready the cycle after the output handshake, never the same one.
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add32_seq.sv
// tb/tb_add32_seq.sv - self-checking bench for add32_seq
module tb_add32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Cout;
`ifdef ADD32_OVERFLOW_EN
  logic        Overflow;
`endif

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  add32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Cout      (Cout)
`ifdef ADD32_OVERFLOW_EN
    ,
    .Overflow  (Overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: plain wide unsigned arithmetic.
  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    longint unsigned t;
    t = longint'(a) + longint'(b) + longint'(cin);
    return t[32:0];
  endfunction

  // Reference: true signed overflow of a + b + cin.
  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check latency, sum and the output handshake.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input string name);
    int n;
    logic [32:0] exp;
    exp = ref_sum(a, b, cin);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    tests++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s in_ready timeout: got %0b want 1", name, in_ready);
    end
    A = a; B = b; Cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    tests++;
    if (n !== 4) begin
      errors++;
      $display("FAIL %s latency: got %0d want 4", name, n);
    end
    tests++;
    if (Result !== exp[31:0] || Cout !== exp[32]) begin
      errors++;
      $display("FAIL %s sum: got %h/%0b want %h/%0b", name, Result, Cout, exp[31:0], exp[32]);
    end
`ifdef ADD32_OVERFLOW_EN
    tests++;
    if (Overflow !== ref_ovf(a, b, cin)) begin
      errors++;
      $display("FAIL %s overflow: got %0b want %0b", name, Overflow, ref_ovf(a, b, cin));
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: got out_valid=%0b in_ready=%0b want 0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    tick(); tick();
    tests++;
    if (out_valid !== 1'b0 || Result !== 32'h0 || Cout !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ov=%0b r=%h c=%0b ir=%0b want 0/0/0/0",
               out_valid, Result, Cout, in_ready);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    run_op(32'h0000000A, 32'h00000005, 1'b0, "small");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "ripple");
    run_op(32'h12345678, 32'h87654321, 1'b0, "pattern");
    run_op(32'h00000005, 32'hFFFFFFF5, 1'b1, "subtract");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "all_ones");
  endtask

  task automatic test_overflow();
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, "ovf_pos");
    run_op(32'h80000000, 32'h80000000, 1'b0, "ovf_neg");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "ovf_none");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op($urandom, $urandom, 1'($urandom), "random");
  endtask

  task automatic test_backpressure();
    int n;
    logic [32:0] exp;
    exp = ref_sum(32'hCAFEF00D, 32'h13572468, 1'b1);
    A = 32'hCAFEF00D; B = 32'h13572468; Cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    // New operands offered while the result is stalled.
    A = 32'h11111111; B = 32'h22222222; Cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          Result !== exp[31:0] || Cout !== exp[32]) begin
        errors++;
        $display("FAIL bp_hold: got ov=%0b ir=%0b r=%h c=%0b want 1/0/%h/%0b",
                 out_valid, in_ready, Result, Cout, exp[31:0], exp[32]);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ir=%0b ov=%0b want 1/0", in_ready, out_valid);
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) n++; end
    tests++;
    if (n !== 0) begin
      errors++;
      $display("FAIL bp_not_taken: got %0d valid cycles want 0", n);
    end
  endtask

  task automatic test_reset_mid_run();
    A = 32'hFFFFFFFF; B = 32'h00000001; Cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || Result !== 32'h0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got ov=%0b r=%h c=%0b want 0/0/0", out_valid, Result, Cout);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_release in_ready: got %0b want 1", in_ready);
    end
    run_op(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int nacc;
    int nres;
    int guard;
    bit took;
    logic [32:0] q[$];
    logic [32:0] exp;
    nacc = 0; nres = 0; guard = 0;
    A = $urandom; B = $urandom; Cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    while (nres < 3 && guard < 100) begin
      took = 1'b0;
      if (in_valid && in_ready) begin
        acc[nacc] = cyc + 1;
        q.push_back(ref_sum(A, B, Cin));
        nacc++;
        took = 1'b1;
      end
      if (out_valid && q.size() > 0) begin
        exp = q.pop_front();
        nres++;
        tests++;
        if (Result !== exp[31:0] || Cout !== exp[32]) begin
          errors++;
          $display("FAIL b2b_sum: got %h/%0b want %h/%0b", Result, Cout, exp[31:0], exp[32]);
        end
      end
      tick();
      guard++;
      if (took) begin
        A = $urandom; B = $urandom; Cin = 1'($urandom);
        if (nacc == 3) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (nres !== 3) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d results want 3", nres);
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (acc[i] - acc[i-1] !== 6) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d cycles want 6", acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
